// File: rtl/lutff_pkg.sv
// Shared op encoding and tree-sizing helpers for the LUT reduction pipe.
package lutff_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_XOR  = 2'b00;
  localparam op_t OP_XNOR = 2'b01;
  localparam op_t OP_AND  = 2'b10;
  localparam op_t OP_OR   = 2'b11;

  // Word width entering tree level n (level 0 sees the raw input word).
  function automatic int lvl_width(int width, int k, int n);
    int w;
    w = width;
    for (int i = 0; i < n; i++) w = (w + k - 1) / k;
    return w;
  endfunction

  // Number of registered levels to reach one bit; a 1-bit word still gets one level.
  function automatic int clog_k(int width, int k);
    int w;
    int l;
    w = width;
    l = 0;
    while (w > 1) begin
      w = (w + k - 1) / k;
      l++;
    end
    return (l < 1) ? 1 : l;
  endfunction

  // Pad value that leaves a group's result unchanged.
  function automatic logic op_identity(op_t op);
    return (op == OP_AND);
  endfunction

endpackage

// File: rtl/lutff_reduce_stage.sv
// One registered tree level: LUT_K-bit groups reduced by the word's op.
module lutff_reduce_stage
  import lutff_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int LUT_K = 4,
  parameter bit FINAL = 1'b0,
  localparam int OUT_W = (IN_W + LUT_K - 1) / LUT_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_vld,
  input  op_t              in_op,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_vld,
  output op_t              out_op,
  output logic [OUT_W-1:0] out_data
);

  localparam int PAD_W = OUT_W * LUT_K;

  logic [PAD_W-1:0] padded;
  logic [OUT_W-1:0] red;

  // Fill the ragged last group with the op identity so it cannot bias the result.
  always_comb begin
    padded = {PAD_W{op_identity(in_op)}};
    padded[IN_W-1:0] = in_data;
  end

  for (genvar g = 0; g < OUT_W; g++) begin : g_grp
    logic [LUT_K-1:0] grp;
    logic             r;
    assign grp = padded[g*LUT_K +: LUT_K];

    // XNOR rides the tree as XOR; only the last level inverts.
    always_comb begin
      r = ^grp;
      case (in_op)
        OP_AND:  r = &grp;
        OP_OR:   r = |grp;
        default: r = ^grp;
      endcase
      if (FINAL && (in_op == OP_XNOR)) r = ~r;
    end

    assign red[g] = r;
  end

  // Advance with the global enable; bubbles move valid only so data holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_op   <= OP_XOR;
      out_data <= '0;
    end else if (adv) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_op   <= in_op;
        out_data <= red;
      end
    end
  end

endmodule

// File: rtl/lutff_reduce_pipe.sv
// Pipelined WIDTH->1 reduction tree with valid/ready on both sides.
module lutff_reduce_pipe
  import lutff_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LUT_K = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data
);

  localparam int LEVELS = clog_k(WIDTH, LUT_K);

  logic             adv;
  logic [LEVELS:0]  vld_pipe;

  // Whole pipe moves together: it only stalls when a result sits unclaimed.
  assign adv         = !out_valid || out_ready;
  assign in_ready    = adv;
  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[LEVELS];

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int IW = lvl_width(WIDTH, LUT_K, i);
    localparam int OW = lvl_width(WIDTH, LUT_K, i + 1);

    op_t           op_i;
    op_t           op_o;
    logic [IW-1:0] d_i;
    logic [OW-1:0] d_o;

    if (i == 0) begin : g_src
      assign op_i = op_t'(in_op);
      assign d_i  = in_data;
    end else begin : g_chain
      assign op_i = g_lvl[i-1].op_o;
      assign d_i  = g_lvl[i-1].d_o;
    end

    lutff_reduce_stage #(
      .IN_W  (IW),
      .LUT_K (LUT_K),
      .FINAL (i == LEVELS - 1)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv),
      .in_vld   (vld_pipe[i]),
      .in_op    (op_i),
      .in_data  (d_i),
      .out_vld  (vld_pipe[i+1]),
      .out_op   (op_o),
      .out_data (d_o)
    );
  end

  assign out_data = g_lvl[LEVELS-1].d_o[0];

endmodule

// File: tb/tb_lutff_reduce_pipe.sv
// Randomized + directed bench for lutff_reduce_pipe (16/4 and 5/4 instances).
module tb_lutff_reduce_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_data;
  logic [15:0] in_data;
  logic [1:0]  in_op;

  logic        in5_valid, in5_ready, out5_valid, out5_data;
  logic [4:0]  in5_data;
  logic [1:0]  in5_op;

  int checks = 0;
  int fails  = 0;
  int nout   = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  lutff_reduce_pipe #(.WIDTH(16), .LUT_K(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  lutff_reduce_pipe #(.WIDTH(5), .LUT_K(4)) u_w5 (
    .clk(clk), .rst(rst), .in_valid(in5_valid), .in_ready(in5_ready),
    .in_data(in5_data), .in_op(in5_op), .out_valid(out5_valid),
    .out_ready(1'b1), .out_data(out5_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count ones over the real width, then apply the op's definition.
  function automatic bit ref_reduce(input logic [15:0] d, input logic [1:0] op, input int w);
    int ones;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    case (op)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return ones == w;
      default: return ones != 0;
    endcase
  endfunction

  // Scoreboard: expected bits queued at input transfer, popped at output transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        nout++;
        if (exp_q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
        else chk("out_data", {31'd0, out_data}, {31'd0, exp_q.pop_front()});
      end
      if (in_valid && in_ready) exp_q.push_back(ref_reduce(in_data, in_op, 16));
    end
  end

  // Single word into an empty pipe: valid must appear exactly two edges later.
  task automatic one_word(input logic [15:0] d, input logic [1:0] op, input bit expv, input string tag);
    in_valid = 1'b1; in_data = d; in_op = op; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom);
    chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {31'd0, out_data}, {31'd0, expv});
    @(posedge clk); #1;
  endtask

  task automatic w5_word(input logic [4:0] d, input logic [1:0] op, input bit expv, input string tag);
    in5_valid = 1'b1; in5_data = d; in5_op = op;
    @(posedge clk); #1;
    in5_valid = 1'b0; in5_data = 5'($urandom);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {31'd0, out5_valid}, 32'd1);
    chk({tag, "_data"}, {31'd0, out5_data}, {31'd0, expv});
    @(posedge clk); #1;
  endtask

  // Producer holds each word until accepted; pv/pr are percent chances of offering / accepting.
  task automatic stream(input int n, input int pv, input int pr, input string tag);
    int idx, cyc;
    bit acc;
    idx = 0; cyc = 0;
    while (idx < n && cyc < 2000) begin
      if (!in_valid) begin
        in_data = 16'($urandom); in_op = 2'($urandom);
        if (int'($urandom_range(99)) < pv) in_valid = 1'b1;
      end
      out_ready = int'($urandom_range(99)) < pr;
      if (pv == 100 && pr == 100) begin
        @(negedge clk);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      end else @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin idx++; in_valid = 1'b0; end
      cyc++;
    end
    chk({tag, "_sent"}, idx, n);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc;
    out_ready = 1'b1; cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int n0, sent;
    bit acc;
    logic [15:0] d;
    logic [1:0]  op;
    logic [4:0]  d5;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
    in5_valid = 1'b0; in5_data = '0; in5_op = '0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {31'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rel_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rel_out_data", {31'd0, out_data}, 32'd0);

    // Latency and basic ops
    one_word(16'h0001, 2'b00, 1'b1, "xor_0001");
    one_word(16'h0003, 2'b01, 1'b1, "xnor_0003");
    one_word(16'h0000, 2'b11, 1'b0, "or_0000");
    one_word(16'hFFFF, 2'b10, 1'b1, "and_ffff");
    one_word(16'hFFFE, 2'b10, 1'b0, "and_fffe");
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom); op = 2'($urandom);
      one_word(d, op, ref_reduce(d, op, 16), "rand_lat");
    end

    // Back-to-back mixed ops: full throughput
    n0 = nout;
    stream(20, 100, 100, "b2b");
    drain("b2b");
    chk("b2b_count", nout - n0, 20);

    // Consumer stall of 5 cycles with 3 words offered
    n0 = nout; sent = 0; out_ready = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) out_ready = 1'b1;
      if (!in_valid && sent < 3) begin
        in_valid = 1'b1; in_data = 16'($urandom); in_op = 2'($urandom);
      end
      @(negedge clk);
      if (out_valid && !out_ready) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin sent++; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    drain("stall");
    chk("stall_sent", sent, 3);
    chk("stall_count", nout - n0, 3);

    // Random valid/ready stress
    n0 = nout;
    stream(60, 70, 60, "stress");
    drain("stress");
    chk("stress_count", nout - n0, 60);

    // Reset with a full, stalled pipe
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 16'($urandom); in_op = 2'($urandom);
      @(posedge clk); #1;
    end
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_data", {31'd0, out_data}, 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = nout; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_count", nout - n0, 0);

    // Narrow instance with a padded group
    w5_word(5'h1F, 2'b10, 1'b1, "w5_and_1f");
    w5_word(5'h00, 2'b01, 1'b1, "w5_xnor_00");
    w5_word(5'h10, 2'b00, 1'b1, "w5_xor_10");
    w5_word(5'h0F, 2'b10, 1'b0, "w5_and_0f");
    for (int i = 0; i < 8; i++) begin
      d5 = 5'($urandom); op = 2'($urandom);
      w5_word(d5, op, ref_reduce({11'd0, d5}, op, 5), "w5_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
